// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
package bram_pkg;

   localparam int WMODE_READ_FIRST  = 0;
   localparam int WMODE_WRITE_FIRST = 1;

   typedef enum logic {
      CLR_IDLE,
      CLR_RUN
   } clr_state_e;

   function automatic int nb(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/bram_dp_if.sv
// Access bus of the dual-port RAM: two ports plus clear/ready/collision.
interface bram_dp_if
   import bram_pkg::*;
#(
   parameter int DW = 32
);
   localparam int NB = nb(DW);

   logic          EN0;
   logic          EN1;
   logic [NB-1:0] WE0;
   logic [NB-1:0] WE1;
   logic [31:0]   A0;
   logic [31:0]   A1;
   logic [DW-1:0] Di0;
   logic [DW-1:0] Di1;
   logic [DW-1:0] Do0;
   logic [DW-1:0] Do1;
   logic          CLR;
   logic          READY;
   logic          COLL;

   modport master (
      output EN0, EN1, WE0, WE1, A0, A1, Di0, Di1, CLR,
      input  Do0, Do1, READY, COLL
   );

   modport slave (
      input  EN0, EN1, WE0, WE1, A0, A1, Di0, Di1, CLR,
      output Do0, Do1, READY, COLL
   );

endinterface

// File: rtl/bram_clr.sv
// Clear sequencer: walks every word once, holding READY low meanwhile.
module bram_clr
   import bram_pkg::*;
#(
   parameter int N          = 14,
   parameter int CLR_ON_RST = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   output logic         ready_o,
   output logic         we_o,
   output logic [N-1:0] addr_o
);

   clr_state_e   state_q;
   logic [N-1:0] cnt_q;
   logic         ready_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= (CLR_ON_RST != 0) ? CLR_RUN : CLR_IDLE;
         cnt_q   <= '0;
         ready_q <= (CLR_ON_RST == 0);
      end else begin
         unique case (state_q)
            CLR_IDLE: begin
               if (clr_i) begin
                  state_q <= CLR_RUN;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            CLR_RUN: begin
               cnt_q <= cnt_q + 1'b1;
               // last word is zeroed on this edge; ports open next cycle
               if (cnt_q == '1) begin
                  state_q <= CLR_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= CLR_IDLE;
         endcase
      end
   end

   assign ready_o = ready_q;
   assign we_o    = (state_q == CLR_RUN);
   assign addr_o  = cnt_q;

endmodule

// File: rtl/bram_dp.sv
// True dual-port byte-enabled block RAM with clear sequencer and
// cross-port write-collision flag.
module bram_dp
   import bram_pkg::*;
#(
   parameter int DW         = 32,
   parameter int N          = 14,
   parameter int OREG       = 0,
   parameter int WMODE      = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic      CLK,
   input  logic      RST_N,
   bram_dp_if.slave  bus
);

   localparam int NB    = nb(DW);
   localparam int DEPTH = 1 << N;

   logic [DW-1:0] mem_q [DEPTH];

   logic          ready;
   logic          clr_we;
   logic [N-1:0]  clr_a;

   logic [N-1:0]  a0;
   logic [N-1:0]  a1;
   logic          act0;
   logic          act1;
   logic [NB-1:0] we0;
   logic [NB-1:0] we1;
   logic          unused_addr;

   logic [DW-1:0] rd0_d, rd0_q;
   logic [DW-1:0] rd1_d, rd1_q;
   logic [DW-1:0] or0_q;
   logic [DW-1:0] or1_q;
   logic          coll_d, coll_q;

   bram_clr #(
      .N          (N),
      .CLR_ON_RST (CLR_ON_RST)
   ) u_clr (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .clr_i   (bus.CLR),
      .ready_o (ready),
      .we_o    (clr_we),
      .addr_o  (clr_a)
   );

   assign a0          = bus.A0[N-1:0];
   assign a1          = bus.A1[N-1:0];
   assign unused_addr = ^{bus.A0[31:N], bus.A1[31:N]};
   assign act0        = ready & bus.EN0;
   assign act1        = ready & bus.EN1;
   assign we0         = act0 ? bus.WE0 : '0;
   assign we1         = act1 ? bus.WE1 : '0;

   // port 0 is applied last so it owns lanes both ports enable
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem_q[clr_a] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (we1[b]) mem_q[a1][8*b +: 8] <= bus.Di1[8*b +: 8];
         end
         for (int b = 0; b < NB; b++) begin
            if (we0[b]) mem_q[a0][8*b +: 8] <= bus.Di0[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd0_d = '0;
      rd1_d = '0;
      if (act0) rd0_d = mem_q[a0];
      if (act1) rd1_d = mem_q[a1];
      if (WMODE == WMODE_WRITE_FIRST) begin
         for (int b = 0; b < NB; b++) begin
            if (we0[b]) rd0_d[8*b +: 8] = bus.Di0[8*b +: 8];
            if (we1[b]) rd1_d[8*b +: 8] = bus.Di1[8*b +: 8];
         end
      end
   end

   assign coll_d = act0 & act1 & (a0 == a1) & (|(bus.WE0 & bus.WE1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd0_q  <= '0;
         rd1_q  <= '0;
         or0_q  <= '0;
         or1_q  <= '0;
         coll_q <= 1'b0;
      end else begin
         rd0_q  <= rd0_d;
         rd1_q  <= rd1_d;
         or0_q  <= rd0_q;
         or1_q  <= rd1_q;
         coll_q <= coll_d;
      end
   end

   assign bus.Do0   = ready ? ((OREG != 0) ? or0_q : rd0_q) : '0;
   assign bus.Do1   = ready ? ((OREG != 0) ? or1_q : rd1_q) : '0;
   assign bus.READY = ready;
   assign bus.COLL  = coll_q;

endmodule
